// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard (stall/flush) controller.
package hazard_pkg;
   localparam int REG_AW_D = 5;
   localparam int CNT_W_D  = 16;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FAULT    = 2'd2
   } state_t;
endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: increments on INC, holds at all-ones.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             INC,
   output logic [CNT_W-1:0] COUNT
);
   logic [CNT_W-1:0] r_count;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)
         r_count <= '0;
      else if (INC && !(&r_count))
         r_count <= r_count + CNT_W'(1);
   end

   assign COUNT = r_count;
endmodule

// File: rtl/hazard_detection_unit.sv
// Stall/flush controller: load-use bubble, taken-branch flush, data-memory wait
// freeze with timeout fault, plus saturating performance counters.
module hazard_detection_unit
   import hazard_pkg::*;
#(
   parameter int REG_AW      = REG_AW_D,
   parameter int CNT_W       = CNT_W_D,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [REG_AW-1:0] RS1_ID,
   input  logic [REG_AW-1:0] RS2_ID,
   input  logic              USES_RS1_ID,
   input  logic              USES_RS2_ID,
   input  logic [REG_AW-1:0] RD_EX,
   input  logic              MEMREAD_EX,
   input  logic              BRANCH_EX,
   input  logic              DMEM_REQ_MEM,
   input  logic              DMEM_ACK,
   output logic              PC_WRITE,
   output logic              IFID_WRITE,
   output logic              IFID_FLUSH,
   output logic              IDEX_WRITE,
   output logic              IDEX_FLUSH,
   output logic              EXMEM_WRITE,
   output logic              MEMWB_BUBBLE,
   output logic              MEM_FAULT,
   output logic [CNT_W-1:0]  STALL_CNT,
   output logic [CNT_W-1:0]  FLUSH_CNT,
   output logic [CNT_W-1:0]  WAIT_CNT
);
   localparam logic [CNT_W-1:0] TMO = CNT_W'(MEM_TIMEOUT);

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_wait_cyc, w_wait_cyc_nxt, w_wait_inc1;
   logic             w_load_use, w_mem_stall;
   logic             w_freeze, w_decode;
   logic             w_stall_inc, w_flush_inc, w_wait_inc;

   assign w_load_use = MEMREAD_EX && (RD_EX != '0) &&
                       ((USES_RS1_ID && (RD_EX == RS1_ID)) ||
                        (USES_RS2_ID && (RD_EX == RS2_ID)));
   assign w_mem_stall = DMEM_REQ_MEM && !DMEM_ACK;
   assign w_wait_inc1 = r_wait_cyc + CNT_W'(1);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state    <= RUN;
         r_wait_cyc <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cyc <= w_wait_cyc_nxt;
      end
   end

   // r_wait_cyc counts freeze cycles of the current memory wait, including the entry cycle
   always_comb begin
      w_state_nxt    = r_state;
      w_wait_cyc_nxt = r_wait_cyc;
      w_freeze       = 1'b0;
      w_decode       = 1'b0;
      w_wait_inc     = 1'b0;
      case (r_state)
         RUN: begin
            if (w_mem_stall) begin
               w_freeze       = 1'b1;
               w_wait_inc     = 1'b1;
               w_wait_cyc_nxt = CNT_W'(1);
               w_state_nxt    = (TMO == CNT_W'(1)) ? FAULT : MEM_WAIT;
            end else begin
               w_decode = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (!DMEM_ACK) begin
               w_freeze       = 1'b1;
               w_wait_inc     = 1'b1;
               w_wait_cyc_nxt = w_wait_inc1;
               if (w_wait_inc1 == TMO) w_state_nxt = FAULT;
            end else begin
               w_decode    = 1'b1;
               w_state_nxt = RUN;
            end
         end
         FAULT:   w_freeze = 1'b1;
         default: w_state_nxt = RUN;
      endcase
   end

   always_comb begin
      PC_WRITE     = 1'b1;
      IFID_WRITE   = 1'b1;
      IFID_FLUSH   = 1'b0;
      IDEX_WRITE   = 1'b1;
      IDEX_FLUSH   = 1'b0;
      EXMEM_WRITE  = 1'b1;
      MEMWB_BUBBLE = 1'b0;
      w_flush_inc  = 1'b0;
      w_stall_inc  = 1'b0;
      if (RESET) begin
         PC_WRITE     = 1'b0;
         IFID_WRITE   = 1'b0;
         IDEX_WRITE   = 1'b0;
         EXMEM_WRITE  = 1'b0;
         IFID_FLUSH   = 1'b1;
         IDEX_FLUSH   = 1'b1;
         MEMWB_BUBBLE = 1'b1;
      end else if (w_freeze) begin
         PC_WRITE     = 1'b0;
         IFID_WRITE   = 1'b0;
         IDEX_WRITE   = 1'b0;
         EXMEM_WRITE  = 1'b0;
         MEMWB_BUBBLE = 1'b1;
      end else if (w_decode && BRANCH_EX) begin
         IFID_FLUSH  = 1'b1;
         IDEX_FLUSH  = 1'b1;
         w_flush_inc = 1'b1;
      end else if (w_decode && w_load_use) begin
         PC_WRITE    = 1'b0;
         IFID_WRITE  = 1'b0;
         IDEX_FLUSH  = 1'b1;
         w_stall_inc = 1'b1;
      end
   end

   assign MEM_FAULT = (r_state == FAULT);

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .CLK(CLK), .RESET(RESET), .INC(w_stall_inc), .COUNT(STALL_CNT));
   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .CLK(CLK), .RESET(RESET), .INC(w_flush_inc), .COUNT(FLUSH_CNT));
   sat_counter #(.CNT_W(CNT_W)) u_wait_cnt (
      .CLK(CLK), .RESET(RESET), .INC(w_wait_inc), .COUNT(WAIT_CNT));
endmodule
